// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: function-select codes, class
// decode masks and the controller state type.
package alu_pkg;

  localparam logic [4:0] FS_ZERO   = 5'b00000;
  localparam logic [4:0] FS_NOR    = 5'b00001;
  localparam logic [4:0] FS_NAB    = 5'b00010;
  localparam logic [4:0] FS_NOTA   = 5'b00011;
  localparam logic [4:0] FS_ANB    = 5'b00100;
  localparam logic [4:0] FS_NOTB   = 5'b00101;
  localparam logic [4:0] FS_XOR    = 5'b00110;
  localparam logic [4:0] FS_NAND   = 5'b00111;
  localparam logic [4:0] FS_AND    = 5'b01000;
  localparam logic [4:0] FS_XNOR   = 5'b01001;
  localparam logic [4:0] FS_PASSB  = 5'b01010;
  localparam logic [4:0] FS_ORNA   = 5'b01011;
  localparam logic [4:0] FS_PASSA  = 5'b01100;
  localparam logic [4:0] FS_ORNB   = 5'b01101;
  localparam logic [4:0] FS_OR     = 5'b01110;
  localparam logic [4:0] FS_ONES   = 5'b01111;
  localparam logic [4:0] FS_INCC   = 5'b10000;
  localparam logic [4:0] FS_NEG    = 5'b10001;
  localparam logic [4:0] FS_INC    = 5'b10010;
  localparam logic [4:0] FS_CSUBA  = 5'b10011;
  localparam logic [4:0] FS_ADD    = 5'b10100;
  localparam logic [4:0] FS_BSUBA  = 5'b10101;
  localparam logic [4:0] FS_SUB    = 5'b10110;
  localparam logic [4:0] FS_NADD   = 5'b10111;
  localparam logic [4:0] FS_SHL    = 5'b11000;
  localparam logic [4:0] FS_SHR    = 5'b11001;
  localparam logic [4:0] FS_SAR    = 5'b11011;
  localparam logic [4:0] FS_ROT    = 5'b11100;

  localparam logic [4:0] FS_LOGIC_MASK = 5'b10000;
  localparam logic [4:0] FS_LOGIC_VAL  = 5'b00000;
  localparam logic [4:0] FS_CLASS_MASK = 5'b11000;
  localparam logic [4:0] FS_ARITH_VAL  = 5'b10000;
  localparam logic [4:0] FS_SHIFT_VAL  = 5'b11000;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  function automatic logic is_logic(input logic [4:0] fs);
    return (fs & FS_LOGIC_MASK) == FS_LOGIC_VAL;
  endfunction

  function automatic logic is_arith(input logic [4:0] fs);
    return (fs & FS_CLASS_MASK) == FS_ARITH_VAL;
  endfunction

  function automatic logic is_shift(input logic [4:0] fs);
    return (fs & FS_CLASS_MASK) == FS_SHIFT_VAL;
  endfunction

endpackage

// File: rtl/alu_pipe_seq_core.sv
// Combinational logic/arithmetic evaluation; shift codes yield zeros here
// because shifting is handled by the sequencer.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [4:0]       fs,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             v
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c;
  logic [WIDTH:0]   sum;

  always_comb begin
    f    = '0;
    cout = 1'b0;
    v    = 1'b0;
    x    = '0;
    y    = '0;
    c    = 1'b0;
    sum  = '0;
    if (is_logic(fs)) begin
      // FS[3:0] is the truth table of the bitwise function, indexed by {a,b}
      for (int unsigned i = 0; i < WIDTH; i++) begin
        f[i] = fs[{a[i], b[i]}];
      end
    end else if (is_arith(fs)) begin
      case (fs[2:0])
        3'd0: begin x = a;  y = '0;          c = cin;  end
        3'd1: begin x = ~a; y = '0;          c = 1'b1; end
        3'd2: begin x = a;  y = WIDTH'(1);   c = cin;  end
        3'd3: begin x = ~a; y = WIDTH'(1);   c = cin;  end
        3'd4: begin x = a;  y = b;           c = cin;  end
        3'd5: begin x = ~a; y = b;           c = cin;  end
        3'd6: begin x = a;  y = ~b;          c = cin;  end
        default: begin x = ~a; y = ~b;       c = cin;  end
      endcase
      sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      f    = sum[WIDTH-1:0];
      cout = sum[WIDTH];
      v    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_pipe_seq.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative
// one-bit-per-cycle shifter.
module alu_pipe_seq
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [SHW-1:0]   SHAMT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             cin_q, cin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;

  logic [WIDTH-1:0] core_f;
  logic             core_cout;
  logic             core_v;
  logic [WIDTH-1:0] step_w;
  logic             step_out;
  logic             accept;
  logic             last_step;
  logic             wr;
  logic [WIDTH-1:0] res_f;
  logic             res_c;
  logic             res_v;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .fs   (FS),
    .a    (A),
    .b    (B),
    .cin  (Cin),
    .f    (core_f),
    .cout (core_cout),
    .v    (core_v)
  );

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == SHW'(1));
  assign busy      = (state_q == SHIFT);
  assign out_valid = out_valid_q;
  assign F         = f_q;
  assign Cout      = cout_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;

  // mode bit 0 = right, bit 1 = arithmetic fill, bit 2 = rotate
  always_comb begin
    step_w   = work_q;
    step_out = 1'b0;
    if (!mode_q[0]) begin
      step_out = work_q[WIDTH-1];
      step_w   = {work_q[WIDTH-2:0], mode_q[2] ? work_q[WIDTH-1] : cin_q};
    end else begin
      step_out = work_q[0];
      step_w   = {mode_q[2] ? work_q[0] : (mode_q[1] & work_q[WIDTH-1]),
                  work_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    out_valid_d = out_valid_q && !out_ready;
    f_d         = f_q;
    cout_d      = cout_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    wr          = 1'b0;
    res_f       = '0;
    res_c       = 1'b0;
    res_v       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift(FS)) begin
            if (SHAMT == '0) begin
              wr    = 1'b1;
              res_f = A;
            end else begin
              work_d  = A;
              cnt_d   = SHAMT;
              mode_d  = FS[2:0];
              cin_d   = Cin;
              state_d = SHIFT;
            end
          end else begin
            wr    = 1'b1;
            res_f = core_f;
            res_c = core_cout;
            res_v = core_v;
          end
        end
      end
      SHIFT: begin
        // Only the result-writing step waits for a held output slot
        if (!(last_step && out_valid_q && !out_ready)) begin
          work_d = step_w;
          cnt_d  = cnt_q - SHW'(1);
          if (last_step) begin
            wr      = 1'b1;
            res_f   = step_w;
            res_c   = step_out;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr) begin
      out_valid_d = 1'b1;
      f_d         = res_f;
      cout_d      = res_c;
      v_d         = res_v;
      z_d         = (res_f == '0);
      n_d         = res_f[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      cout_q      <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      cout_q      <= cout_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Directed and random checks of alu_pipe_seq against an arithmetic
// reference model of the function map, shifts and handshake timing.
module tb_alu_pipe_seq;

  localparam int unsigned W   = 16;
  localparam int unsigned SHW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4:0]     FS = '0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           Cin = 1'b0;
  logic [SHW-1:0] SHAMT = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   F;
  logic           Cout;
  logic           Z;
  logic           N;
  logic           V;
  logic           busy;

  int errors = 0;
  int checks = 0;

  alu_pipe_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .FS        (FS),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .SHAMT     (SHAMT),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .Cout      (Cout),
    .Z         (Z),
    .N         (N),
    .V         (V),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from the function table and plain arithmetic
  task automatic model(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [SHW-1:0] k,
                       output logic [W-1:0] ef, output logic ec, output logic ev,
                       output int lat);
    logic [W-1:0] x, y;
    logic         c;
    logic [W:0]   s;
    int           ss, kk;
    ef = '0; ec = 1'b0; ev = 1'b0; lat = 0;
    x = '0; y = '0; c = 1'b0;
    if (fs[4] == 1'b0) begin
      case (fs[3:0])
        4'd0:  ef = '0;
        4'd1:  ef = ~(a | b);
        4'd2:  ef = ~a & b;
        4'd3:  ef = ~a;
        4'd4:  ef = a & ~b;
        4'd5:  ef = ~b;
        4'd6:  ef = a ^ b;
        4'd7:  ef = ~(a & b);
        4'd8:  ef = a & b;
        4'd9:  ef = ~(a ^ b);
        4'd10: ef = b;
        4'd11: ef = ~a | b;
        4'd12: ef = a;
        4'd13: ef = a | ~b;
        4'd14: ef = a | b;
        default: ef = '1;
      endcase
    end else if (fs[3] == 1'b0) begin
      case (fs[2:0])
        3'd0: begin x = a;  y = 0; c = cin;  end
        3'd1: begin x = ~a; y = 0; c = 1'b1; end
        3'd2: begin x = a;  y = 1; c = cin;  end
        3'd3: begin x = ~a; y = 1; c = cin;  end
        3'd4: begin x = a;  y = b; c = cin;  end
        3'd5: begin x = ~a; y = b; c = cin;  end
        3'd6: begin x = a;  y = ~b; c = cin; end
        default: begin x = ~a; y = ~b; c = cin; end
      endcase
      s  = {1'b0, x} + {1'b0, y} + c;
      ef = s[W-1:0];
      ec = s[W];
      ss = int'($signed(x)) + int'($signed(y)) + int'(c);
      ev = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    end else begin
      kk = int'(k);
      lat = kk;
      if (kk == 0) begin
        ef = a;
      end else if (fs[0] == 1'b0) begin
        ec = a[W - kk];
        if (fs[2]) ef = (a << kk) | (a >> (W - kk));
        else       ef = (a << kk) | (cin ? ((W'(1) << kk) - W'(1)) : '0);
      end else begin
        ec = a[kk - 1];
        if (fs[2])      ef = (a >> kk) | (a << (W - kk));
        else if (fs[1]) ef = W'($signed(a) >>> kk);
        else            ef = a >> kk;
      end
    end
  endtask

  task automatic do_op(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [SHW-1:0] k);
    logic [W-1:0] ef;
    logic         ec, ev;
    int           lat, n;
    model(fs, a, b, cin, k, ef, ec, ev, lat);
    FS = fs; A = a; B = b; Cin = cin; SHAMT = k;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    FS = 5'($urandom); A = W'($urandom); B = W'($urandom);
    Cin = 1'($urandom); SHAMT = SHW'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      chk("busy_during_shift", 32'(busy), 32'd1);
      chk("in_ready_while_busy", 32'(in_ready), 32'd0);
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("F", 32'(F), 32'(ef));
    chk("Cout", 32'(Cout), 32'(ec));
    chk("V", 32'(V), 32'(ev));
    chk("Z", 32'(Z), 32'(ef == '0));
    chk("N", 32'(N), 32'(ef[W-1]));
    tick();
    chk("out_valid_cleared", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         seen;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_F", 32'(F), 32'd0);
    chk("rst_flags", 32'({Cout, Z, N, V}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    do_op(5'b10100, 16'hFFFF, 16'h0001, 1'b0, 4'd0);
    do_op(5'b10100, 16'h7FFF, 16'h0001, 1'b0, 4'd0);
    do_op(5'b11000, 16'h8001, 16'h0000, 1'b1, 4'd3);
    do_op(5'b11011, 16'h8000, 16'h0000, 1'b0, 4'd4);
    do_op(5'b11101, 16'h0001, 16'h0000, 1'b0, 4'd1);
    do_op(5'b11100, 16'h8001, 16'h0000, 1'b0, 4'd0);
    do_op(5'b11001, 16'h8001, 16'h0000, 1'b1, 4'd15);
    do_op(5'b10001, 16'h8000, 16'h0000, 1'b0, 4'd0);

    // Backpressure: result held while consumer stalls
    FS = 5'b00110; A = 16'hAAAA; B = 16'hFFFF; Cin = 1'b0; SHAMT = '0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_F", 32'(F), 32'h5555);
    held = F;
    FS = 5'b10100; A = 16'h0001; B = 16'h0002;
    repeat (5) begin
      tick();
      chk("bp_F_stable", 32'(F), 32'(held));
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_F", 32'(F), 32'h0003);
    // Back-to-back single-cycle ops at full rate
    FS = 5'b01000; A = 16'hF0F0; B = 16'h3C3C;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("b2b_F", 32'(F), 32'h3030);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset during the second cycle of an 8-step shift
    FS = 5'b11000; A = 16'h1234; Cin = 1'b1; SHAMT = 4'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rs_busy", 32'(busy), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_F", 32'(F), 32'd0);
    chk("rs_busy_cleared", 32'(busy), 32'd0);
    chk("rs_flags", 32'({Cout, Z, N, V}), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | out_valid;
    end
    chk("rs_no_result", 32'(seen), 32'd0);

    for (int i = 0; i < 80; i++) begin
      do_op(5'($urandom_range(0, 31)), W'($urandom), W'($urandom),
            1'($urandom), SHW'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
